pe_affine2_param: RTL and testbench
===================================

// Module: pe_affine2_param
// PURPOSE
//  Parametrised processing element for the two-piece affine-gap systolic array.
//  Holds one query base (s), scores one cell per valid cycle against the streamed target base (t),
//  and forwards H/F/F_hat, the running max and traceback direction to the next PE.
//  Adds over the previous PE: runtime local/global mode, saturating arithmetic,
//  multi-pass operation via last_in, and an explicit per-cell source/extension code.
// PARAMETERS
//  BP_W      2   base width
//  CALC_W    16  signed score width
//  ADDR_W    10  row counter / traceback address width
//  PE_IDX    0   column index of this PE (0-based)
//  MATCH     2   match score (added)
//  MISMATCH  4   mismatch penalty (subtracted)
//  Q, E      4,2   short gap open/extend penalties
//  Q_HAT, E_HAT  24,1  long gap open/extend penalties
// PORTS
//  clk           in  1         clock, rising edge
//  reset_i       in  1         asynchronous reset, active low
//  mode_local_i  in  1         1 = local (clamp at 0), 0 = global
//  s_in          in  BP_W      query base shifted in along the chain
//  s_update_in   in  1         load s_in into the s register
//  t_in          in  BP_W      target base for this cycle
//  valid_in      in  1         t_in/H_in/F_in/F_hat_in valid this cycle
//  last_in       in  1         qualifies valid_in: final row of this pass
//  H_in          in  CALC_W    H(i,j-1) from the upstream PE
//  F_in          in  CALC_W    F(i,j-1) short-gap horizontal score
//  F_hat_in      in  CALC_W    F_hat(i,j-1) long-gap horizontal score
//  max_in        in  CALC_W    running max from upstream
//  max_pos_in    in  2*ADDR_W  {row,col} of max_in
//  s_out, t_out, s_update_out, valid_out, last_out   out  as inputs  1-cycle registered copies
//  H_out         out CALC_W    H(i,j)
//  F_out, F_hat_out  out CALC_W  F(i,j), F_hat(i,j)
//  max_out       out CALC_W    running max including this PE
//  max_pos_out   out 2*ADDR_W  {row,col} of max_out
//  dir_out       out 7         {src[2:0],E_ext,Eh_ext,F_ext,Fh_ext} for cell (addr_out,PE_IDX)
//  addr_out      out ADDR_W    row index of the cell on H_out/dir_out (traceback write address)
// BEHAVIOUR
//  - Reset (async, low): every register and output = 0; row counter = 0; first_row = 1; s register = 0.
//  - Latency: all outputs registered; a valid_in at edge n appears on valid_out, H_out, dir_out and addr_out after edge n+1.
//  - s register loads s_in when s_update_in = 1. Scoring uses the pre-edge s value; a load with valid_in set takes effect next cell.
//  - Per valid cell, all terms sat = clamp to [-2^(CALC_W-1), 2^(CALC_W-1)-1], computed in CALC_W+1 bits:
//    F = max(F_in-E, H_in-Q-E); Fh = max(F_hat_in-E_HAT, H_in-Q_HAT-E_HAT); E/Eh from own previous H_out/E regs likewise.
//    diag = Hd + (s==t ? MATCH : -MISMATCH); Hd = H_in registered on the previous valid cycle.
//    H = max(diag, E, Eh, F, Fh) and, in local mode only, max(H, 0).
//  - First row of a pass (first_row = 1):
//    * E and Eh = most-negative value.
//    * Hd = 0 in local mode; in global mode Hd = -min(Q+E*PE_IDX, Q_HAT+E_HAT*PE_IDX), or 0 if PE_IDX = 0.
//  - Tie rules:
//    * src priority diag(001) > E(010) > Eh(011) > F(100) > Fh(101); zero(000) only if local mode and best < 0.
//    * *_ext = 1 when extend >= open.
//  - Max: if valid and H > max_in, then max_out = H and max_pos_out = {row,PE_IDX}; otherwise pass max_in/max_pos_in (tie keeps upstream).
//  - Row counter increments per valid cell and wraps modulo 2^ADDR_W.
//    valid_in & last_in: counter -> 0, first_row -> 1, E/Eh cleared after the cell.
//  - mode_local_i is latched on the first valid of a pass and held until last; mid-pass changes are ignored.
//  - valid_in = 0: H/E/F state holds; valid_out = 0; max passes through registered.
//  - reset_i asserted mid-pass aborts immediately; the next pass starts at row 0.
// TESTING
//  - Drive reset_i low mid-pass (row 5) -> all outputs 0 asynchronously; after release the first valid gives addr_out = 0.
//  - Local, PE_IDX=0, s=t=0, H_in=F_in=F_hat_in=-32768 -> H_out=2, src=001, max_out=2, max_pos_out={0,0}.
//  - Local, s=0, t=1, same inputs -> diag=-4, clamped: H_out=0, src=000.
//  - Global, PE_IDX=3, s=t, H/F inputs=-32768 -> Hd=-10, H_out=-8, src=001; F_in=-32768 saturates (no wrap).
//  - Global, PE_IDX=0, row0 match then 24 mismatched rows with inputs=-32768 -> H(k)=2-min(4+2k,24+k):
//    src=E through k=20 (tie), src=Eh from k=21 (H=-43).
//  - Pass with last_in on row 7, next pass back-to-back with mode flipped and s_update_in coincident with valid
//    -> addr_out 7 then 0; new mode and new s used from the next cell.

Source files
------------

// File: rtl/pe_affine2_param_if.sv
// Payload bundle passed between neighbouring PEs of the two-piece affine-gap array.
// dir/addr leave the chain towards the traceback memory, so the slave side omits them.
interface pe_affine2_param_if #(
  parameter int unsigned BP_W   = 2,
  parameter int unsigned CALC_W = 16,
  parameter int unsigned ADDR_W = 10
);
  logic        [BP_W-1:0]     s;
  logic                       s_update;
  logic        [BP_W-1:0]     t;
  logic                       valid;
  logic                       last;
  logic signed [CALC_W-1:0]   h;
  logic signed [CALC_W-1:0]   f;
  logic signed [CALC_W-1:0]   f_hat;
  logic signed [CALC_W-1:0]   max;
  logic        [2*ADDR_W-1:0] max_pos;
  logic        [6:0]          dir;
  logic        [ADDR_W-1:0]   addr;

  modport master (output s, s_update, t, valid, last, h, f, f_hat, max, max_pos, dir, addr);
  modport slave  (input  s, s_update, t, valid, last, h, f, f_hat, max, max_pos);
endinterface

// File: rtl/pe_affine2_param.sv
// Two-piece affine-gap systolic PE: scores one cell per valid cycle against a resident
// query base and forwards H/F/F_hat, the running max and a per-cell traceback code.
module pe_affine2_param #(
  parameter int unsigned BP_W     = 2,
  parameter int unsigned CALC_W   = 16,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned PE_IDX   = 0,
  parameter int          MATCH    = 2,
  parameter int          MISMATCH = 4,
  parameter int          Q        = 4,
  parameter int          E        = 2,
  parameter int          Q_HAT    = 24,
  parameter int          E_HAT    = 1
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               mode_local_i,
  pe_affine2_param_if.slave  up,
  pe_affine2_param_if.master dn
);
  localparam int unsigned XW = CALC_W + 1;
  typedef logic signed [CALC_W-1:0] sc_t;
  typedef logic signed [XW-1:0]     xs_t;

  localparam sc_t SC_MIN = sc_t'({1'b1, {(CALC_W-1){1'b0}}});
  localparam sc_t SC_MAX = sc_t'({1'b0, {(CALC_W-1){1'b1}}});
  localparam xs_t K_E    = xs_t'(E);
  localparam xs_t K_QE   = xs_t'(Q + E);
  localparam xs_t K_EH   = xs_t'(E_HAT);
  localparam xs_t K_QEH  = xs_t'(Q_HAT + E_HAT);
  localparam xs_t K_MAT  = xs_t'(MATCH);
  localparam xs_t K_MIS  = xs_t'(-MISMATCH);
  localparam int  GAP_S  = Q + E * int'(PE_IDX);
  localparam int  GAP_L  = Q_HAT + E_HAT * int'(PE_IDX);
  // Global-mode boundary: cheapest gap that reaches this column from the origin.
  localparam sc_t HD_GLOBAL = (PE_IDX == 0) ? '0 : sc_t'(-((GAP_S < GAP_L) ? GAP_S : GAP_L));

  function automatic xs_t ext(input sc_t v);
    return {v[CALC_W-1], v};
  endfunction

  function automatic sc_t sat(input xs_t v);
    if (v[XW-1] != v[XW-2]) return v[XW-1] ? SC_MIN : SC_MAX;
    return v[CALC_W-1:0];
  endfunction

  function automatic sc_t smax(input sc_t a, input sc_t b);
    return (a >= b) ? a : b;
  endfunction

  sc_t h_in, f_in, fh_in, max_in;
  assign h_in   = up.h;
  assign f_in   = up.f;
  assign fh_in  = up.f_hat;
  assign max_in = up.max;

  logic [BP_W-1:0]     s_q, s_d, s_fwd_q, s_fwd_d, t_q, t_d;
  logic [ADDR_W-1:0]   row_q, row_d, addr_q, addr_d;
  logic                first_row_q, first_row_d, mode_q, mode_d;
  logic                valid_q, valid_d, last_q, last_d, s_upd_q, s_upd_d;
  sc_t                 hd_q, hd_d, h_q, h_d, e_q, e_d, eh_q, eh_d;
  sc_t                 f_q, f_d, fh_q, fh_d, max_q, max_d;
  logic [2*ADDR_W-1:0] max_pos_q, max_pos_d;
  logic [6:0]          dir_q, dir_d;

  logic                mode_eff;
  sc_t                 hd, diag, best;
  sc_t                 f_ext, f_opn, fh_ext, fh_opn, e_ext, e_opn, eh_ext, eh_opn;
  sc_t                 f_val, fh_val, e_val, eh_val;
  logic [2:0]          src;

  // Cell score: the earliest candidate wins ties (diag, E, Eh, F, Fh).
  always_comb begin
    mode_eff = first_row_q ? mode_local_i : mode_q;
    hd       = first_row_q ? (mode_eff ? '0 : HD_GLOBAL) : hd_q;
    diag     = sat(ext(hd) + ((s_q == up.t) ? K_MAT : K_MIS));
    f_ext    = sat(ext(f_in)  - K_E);
    f_opn    = sat(ext(h_in)  - K_QE);
    fh_ext   = sat(ext(fh_in) - K_EH);
    fh_opn   = sat(ext(h_in)  - K_QEH);
    e_ext    = sat(ext(e_q)   - K_E);
    e_opn    = sat(ext(h_q)   - K_QE);
    eh_ext   = sat(ext(eh_q)  - K_EH);
    eh_opn   = sat(ext(h_q)   - K_QEH);
    f_val    = smax(f_ext, f_opn);
    fh_val   = smax(fh_ext, fh_opn);
    e_val    = first_row_q ? SC_MIN : smax(e_ext, e_opn);
    eh_val   = first_row_q ? SC_MIN : smax(eh_ext, eh_opn);

    best = diag;
    src  = 3'b001;
    if (e_val  > best) begin best = e_val;  src = 3'b010; end
    if (eh_val > best) begin best = eh_val; src = 3'b011; end
    if (f_val  > best) begin best = f_val;  src = 3'b100; end
    if (fh_val > best) begin best = fh_val; src = 3'b101; end
    if (mode_eff && best[CALC_W-1]) begin
      best = '0;
      src  = 3'b000;
    end
  end

  // Next-state: datapath state only advances on valid cells.
  always_comb begin
    s_d         = up.s_update ? up.s : s_q;
    s_fwd_d     = up.s;
    t_d         = up.t;
    s_upd_d     = up.s_update;
    last_d      = up.last;
    valid_d     = up.valid;
    row_d       = row_q;
    first_row_d = first_row_q;
    mode_d      = mode_q;
    hd_d        = hd_q;
    h_d         = h_q;
    e_d         = e_q;
    eh_d        = eh_q;
    f_d         = f_q;
    fh_d        = fh_q;
    dir_d       = dir_q;
    addr_d      = addr_q;
    max_d       = max_in;
    max_pos_d   = up.max_pos;
    if (up.valid) begin
      mode_d = mode_eff;
      hd_d   = h_in;
      h_d    = best;
      e_d    = up.last ? SC_MIN : e_val;
      eh_d   = up.last ? SC_MIN : eh_val;
      f_d    = f_val;
      fh_d   = fh_val;
      addr_d = row_q;
      dir_d  = {src, !first_row_q && (e_ext >= e_opn), !first_row_q && (eh_ext >= eh_opn),
                f_ext >= f_opn, fh_ext >= fh_opn};
      row_d       = up.last ? '0 : row_q + ADDR_W'(1);
      first_row_d = up.last;
      if (best > max_in) begin
        max_d     = best;
        max_pos_d = {row_q, ADDR_W'(PE_IDX)};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      s_q <= '0; s_fwd_q <= '0; t_q <= '0; s_upd_q <= 1'b0; last_q <= 1'b0; valid_q <= 1'b0;
      row_q <= '0; first_row_q <= 1'b1; mode_q <= 1'b0; hd_q <= '0; h_q <= '0;
      e_q <= '0; eh_q <= '0; f_q <= '0; fh_q <= '0; dir_q <= '0; addr_q <= '0;
      max_q <= '0; max_pos_q <= '0;
    end else begin
      s_q <= s_d; s_fwd_q <= s_fwd_d; t_q <= t_d; s_upd_q <= s_upd_d; last_q <= last_d;
      valid_q <= valid_d; row_q <= row_d; first_row_q <= first_row_d; mode_q <= mode_d;
      hd_q <= hd_d; h_q <= h_d; e_q <= e_d; eh_q <= eh_d; f_q <= f_d; fh_q <= fh_d;
      dir_q <= dir_d; addr_q <= addr_d; max_q <= max_d; max_pos_q <= max_pos_d;
    end
  end

  assign dn.s        = s_fwd_q;
  assign dn.s_update = s_upd_q;
  assign dn.t        = t_q;
  assign dn.valid    = valid_q;
  assign dn.last     = last_q;
  assign dn.h        = h_q;
  assign dn.f        = f_q;
  assign dn.f_hat    = fh_q;
  assign dn.max      = max_q;
  assign dn.max_pos  = max_pos_q;
  assign dn.dir      = dir_q;
  assign dn.addr     = addr_q;
endmodule

// File: tb/tb_pe_affine2_param.sv
// Bench for pe_affine2_param: PE_IDX 0 and 3 share one upstream bundle and are checked
// every cycle against a plain-arithmetic recurrence model, plus directed corner cases.
module tb_pe_affine2_param;
  localparam int NEG = -32768;

  logic clk;
  logic reset_i;
  logic mode_local_i;

  pe_affine2_param_if up ();
  pe_affine2_param_if dn0 ();
  pe_affine2_param_if dn3 ();

  pe_affine2_param #(.PE_IDX(0)) u_pe0 (.clk(clk), .reset_i(reset_i), .mode_local_i(mode_local_i),
                                        .up(up), .dn(dn0));
  pe_affine2_param #(.PE_IDX(3)) u_pe3 (.clk(clk), .reset_i(reset_i), .mode_local_i(mode_local_i),
                                        .up(up), .dn(dn3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp, n_err;
  int in_valid, in_last, in_su, in_s, in_t, in_h, in_f, in_fh, in_max, in_pos, in_mode;

  // Reference model state (index 0 -> PE 0, index 1 -> PE 3)
  int m_s[2], m_row[2], m_first[2], m_mode[2], m_hd[2], m_h[2], m_e[2], m_eh[2];
  int x_valid[2], x_h[2], x_f[2], x_fh[2], x_max[2], x_pos[2], x_dir[2], x_addr[2];
  int x_s[2], x_t[2], x_last[2], x_su[2];

  typedef struct {
    int mode; int t;
    int exp_h0; int exp_src0; int exp_max0; int exp_h3; int exp_src3;
  } tv_t;
  tv_t tv[4];

  function automatic int sat(input int v);
    if (v < -32768) return -32768;
    if (v > 32767) return 32767;
    return v;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a >= b) ? a : b;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a <= b) ? a : b;
  endfunction

  function automatic int rnd_score();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return NEG;
    if (r == 1) return 32767;
    return int'($urandom_range(0, 2000)) - 1000;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_s[p] = 0; m_row[p] = 0; m_first[p] = 1; m_mode[p] = 0; m_hd[p] = 0;
      m_h[p] = 0; m_e[p] = 0; m_eh[p] = 0;
      x_valid[p] = 0; x_h[p] = 0; x_f[p] = 0; x_fh[p] = 0; x_max[p] = 0; x_pos[p] = 0;
      x_dir[p] = 0; x_addr[p] = 0; x_s[p] = 0; x_t[p] = 0; x_last[p] = 0; x_su[p] = 0;
    end
  endtask

  task automatic model_step(input int p);
    int pe, md, hd, diag, fe, fo, fhe, fho, ee, eo, ehe, eho, best, src;
    int cand[5];
    int xe, xeh;
    pe = (p == 0) ? 0 : 3;
    if (in_valid != 0) begin
      md = (m_first[p] != 0) ? in_mode : m_mode[p];
      if (m_first[p] == 0)          hd = m_hd[p];
      else if (md != 0 || pe == 0)  hd = 0;
      else                          hd = -imin(4 + 2 * pe, 24 + pe);
      diag = sat(hd + ((m_s[p] == in_t) ? 2 : -4));
      fe  = sat(in_f - 2);     fo  = sat(in_h - 6);
      fhe = sat(in_fh - 1);    fho = sat(in_h - 25);
      ee  = sat(m_e[p] - 2);   eo  = sat(m_h[p] - 6);
      ehe = sat(m_eh[p] - 1);  eho = sat(m_h[p] - 25);
      cand[0] = diag;
      cand[1] = (m_first[p] != 0) ? NEG : imax(ee, eo);
      cand[2] = (m_first[p] != 0) ? NEG : imax(ehe, eho);
      cand[3] = imax(fe, fo);
      cand[4] = imax(fhe, fho);
      best = cand[0]; src = 1;
      for (int i = 1; i < 5; i++) if (cand[i] > best) begin best = cand[i]; src = i + 1; end
      if (md != 0 && best < 0) begin best = 0; src = 0; end
      xe  = (m_first[p] == 0 && ee >= eo) ? 1 : 0;
      xeh = (m_first[p] == 0 && ehe >= eho) ? 1 : 0;
      x_dir[p]  = src * 16 + xe * 8 + xeh * 4 + ((fe >= fo) ? 2 : 0) + ((fhe >= fho) ? 1 : 0);
      x_h[p] = best; x_f[p] = cand[3]; x_fh[p] = cand[4];
      x_addr[p] = m_row[p]; x_valid[p] = 1;
      if (best > in_max) begin x_max[p] = best; x_pos[p] = m_row[p] * 1024 + pe; end
      else begin x_max[p] = in_max; x_pos[p] = in_pos; end
      m_mode[p] = md; m_hd[p] = in_h; m_h[p] = best; m_e[p] = cand[1]; m_eh[p] = cand[2];
      if (in_last != 0) begin m_row[p] = 0; m_first[p] = 1; end
      else begin m_row[p] = (m_row[p] + 1) % 1024; m_first[p] = 0; end
    end else begin
      x_valid[p] = 0; x_max[p] = in_max; x_pos[p] = in_pos;
    end
    x_s[p] = in_s; x_t[p] = in_t; x_last[p] = in_last; x_su[p] = in_su;
    if (in_su != 0) m_s[p] = in_s;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_pe(input int p, input int v, input int h, input int f, input int fh,
                        input int mx, input int pos, input int dir, input int addr,
                        input int s, input int t, input int l, input int su);
    string px;
    px = (p == 0) ? "pe0" : "pe3";
    chk({px, ".valid"}, v, x_valid[p]);
    chk({px, ".h"}, h, x_h[p]);
    chk({px, ".f"}, f, x_f[p]);
    chk({px, ".f_hat"}, fh, x_fh[p]);
    chk({px, ".max"}, mx, x_max[p]);
    chk({px, ".max_pos"}, pos, x_pos[p]);
    chk({px, ".dir"}, dir, x_dir[p]);
    chk({px, ".addr"}, addr, x_addr[p]);
    chk({px, ".s_out"}, s, x_s[p]);
    chk({px, ".t_out"}, t, x_t[p]);
    chk({px, ".last_out"}, l, x_last[p]);
    chk({px, ".s_update_out"}, su, x_su[p]);
  endtask

  task automatic check_all();
    chk_pe(0, int'(dn0.valid), int'(dn0.h), int'(dn0.f), int'(dn0.f_hat), int'(dn0.max),
           int'(dn0.max_pos), int'(dn0.dir), int'(dn0.addr), int'(dn0.s), int'(dn0.t),
           int'(dn0.last), int'(dn0.s_update));
    chk_pe(1, int'(dn3.valid), int'(dn3.h), int'(dn3.f), int'(dn3.f_hat), int'(dn3.max),
           int'(dn3.max_pos), int'(dn3.dir), int'(dn3.addr), int'(dn3.s), int'(dn3.t),
           int'(dn3.last), int'(dn3.s_update));
  endtask

  task automatic drive(input int v, input int l, input int su, input int s, input int t,
                       input int h, input int f, input int fh, input int mx, input int pos,
                       input int mode);
    in_valid = v; in_last = l; in_su = su; in_s = s; in_t = t; in_h = h; in_f = f;
    in_fh = fh; in_max = mx; in_pos = pos; in_mode = mode;
    up.valid = 1'(v); up.last = 1'(l); up.s_update = 1'(su); up.s = 2'(s); up.t = 2'(t);
    up.h = 16'(h); up.f = 16'(f); up.f_hat = 16'(fh); up.max = 16'(mx);
    up.max_pos = 20'(pos); mode_local_i = 1'(mode);
  endtask

  task automatic cycle();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int exp_h, exp_src;
    n_cmp = 0; n_err = 0;
    up.dir = '0; up.addr = '0;
    tv[0] = '{mode: 1, t: 0, exp_h0: 2,  exp_src0: 1, exp_max0: 2, exp_h3: 2,   exp_src3: 1};
    tv[1] = '{mode: 1, t: 1, exp_h0: 0,  exp_src0: 0, exp_max0: 0, exp_h3: 0,   exp_src3: 0};
    tv[2] = '{mode: 0, t: 0, exp_h0: 2,  exp_src0: 1, exp_max0: 2, exp_h3: -8,  exp_src3: 1};
    tv[3] = '{mode: 0, t: 1, exp_h0: -4, exp_src0: 1, exp_max0: -4, exp_h3: -14, exp_src3: 1};

    reset_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, NEG, 0, 1);
    #1 reset_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    check_all();
    reset_i = 1'b1;

    // Single-cell passes from the spec examples (s register = 0, inputs at most-negative)
    foreach (tv[i]) begin
      drive(1, 1, 0, 0, tv[i].t, NEG, NEG, NEG, NEG, 0, tv[i].mode);
      cycle();
      chk("tbl_h0", int'(dn0.h), tv[i].exp_h0);
      chk("tbl_src0", int'(dn0.dir[6:4]), tv[i].exp_src0);
      chk("tbl_max0", int'(dn0.max), tv[i].exp_max0);
      chk("tbl_h3", int'(dn3.h), tv[i].exp_h3);
      chk("tbl_src3", int'(dn3.dir[6:4]), tv[i].exp_src3);
    end

    // Global: row0 match, then 24 mismatched rows; short gap wins until the k=20 tie
    for (int k = 0; k < 25; k++) begin
      drive(1, (k == 24) ? 1 : 0, 0, 0, (k == 0) ? 0 : 1, NEG, NEG, NEG, NEG, 0, 0);
      cycle();
      exp_h   = (k == 0) ? 2 : 2 - imin(4 + 2 * k, 24 + k);
      exp_src = (k == 0) ? 1 : ((k <= 20) ? 2 : 3);
      chk("gap_h", int'(dn0.h), exp_h);
      chk("gap_src", int'(dn0.dir[6:4]), exp_src);
      chk("gap_addr", int'(dn0.addr), k);
    end

    // Reset asserted during row 5 of a pass
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 0, int'($urandom_range(0, 3)), rnd_score(), rnd_score(), rnd_score(),
            NEG, 0, 1);
      cycle();
    end
    drive(1, 0, 0, 0, 1, 50, 50, 50, NEG, 0, 1);
    #2 reset_i = 1'b0;
    model_reset();
    #1;
    check_all();
    #2 reset_i = 1'b1;
    drive(1, 0, 0, 0, 0, NEG, NEG, NEG, NEG, 0, 1);
    cycle();
    chk("rst_addr0", int'(dn0.addr), 0);
    drive(1, 1, 0, 0, 2, NEG, NEG, NEG, NEG, 0, 1);
    cycle();

    // Pass ending on row 7, then a back-to-back pass with flipped mode and new s
    for (int k = 0; k < 8; k++) begin
      drive(1, (k == 7) ? 1 : 0, 0, 0, int'($urandom_range(0, 3)), rnd_score(), rnd_score(),
            rnd_score(), NEG, 0, 0);
      cycle();
    end
    chk("pass_addr7", int'(dn0.addr), 7);
    drive(1, 0, 1, 2, 0, NEG, NEG, NEG, NEG, 0, 1);
    cycle();
    chk("pass_addr0", int'(dn0.addr), 0);
    chk("old_s_h", int'(dn0.h), 2);
    chk("old_s_src", int'(dn0.dir[6:4]), 1);
    drive(1, 0, 0, 2, 2, 100, NEG, NEG, NEG, 0, 0);
    cycle();
    chk("pass_addr1", int'(dn0.addr), 1);
    drive(1, 0, 0, 2, 2, NEG, NEG, NEG, NEG, 0, 0);
    cycle();
    chk("new_s_h", int'(dn0.h), 102);
    chk("new_s_src", int'(dn0.dir[6:4]), 1);
    drive(1, 1, 0, 2, 3, NEG, NEG, NEG, NEG, 0, 0);
    cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 3) != 0) ? 1 : 0, ($urandom_range(0, 15) == 0) ? 1 : 0,
            ($urandom_range(0, 7) == 0) ? 1 : 0, int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), rnd_score(), rnd_score(), rnd_score(), rnd_score(),
            int'($urandom_range(0, 1048575)), int'($urandom_range(0, 1)));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
